// File: rtl/clut_prom_arbiter_if.sv
// Bus bundle for clut_prom_arbiter.
// Groups the video lookup path, the loader/debug port, the overrun flag and both
// colour PROM memory buses (3R: 8-bit red/green, 3S: 4-bit blue).
//   slave  : arbiter view (takes requests, drives the PROM buses)
//   master : environment view (video generator, loader, PROM memories)
interface clut_prom_arbiter_if #(
  parameter int unsigned ADDR_W = 9
) ();
  // Video lookup path
  logic              pix_en;
  logic [ADDR_W-1:0] vid_addr;
  logic [7:0]        vid_r_data;
  logic [3:0]        vid_s_data;
  logic              vid_valid;
  logic              blank;
  // Loader / debug port
  logic              ld_req;
  logic              ld_we;
  logic              ld_sel;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_wdata;
  logic              ld_ack;
  logic [7:0]        ld_rdata;
  // Status
  logic              vid_overrun;
  logic              overrun_clr;
  // PROM 3R
  logic [ADDR_W-1:0] prom_3r_addr;
  logic [7:0]        prom_3r_data;
  logic [7:0]        prom_3r_wdata;
  logic              prom_3r_we;
  logic              prom_3r_ce;
  // PROM 3S
  logic [ADDR_W-1:0] prom_3s_addr;
  logic [3:0]        prom_3s_data;
  logic [3:0]        prom_3s_wdata;
  logic              prom_3s_we;
  logic              prom_3s_ce;

  modport slave (
    input  pix_en, vid_addr, blank, ld_req, ld_we, ld_sel, ld_addr, ld_wdata, overrun_clr,
           prom_3r_data, prom_3s_data,
    output vid_r_data, vid_s_data, vid_valid, ld_ack, ld_rdata, vid_overrun,
           prom_3r_addr, prom_3r_wdata, prom_3r_we, prom_3r_ce,
           prom_3s_addr, prom_3s_wdata, prom_3s_we, prom_3s_ce
  );

  modport master (
    output pix_en, vid_addr, blank, ld_req, ld_we, ld_sel, ld_addr, ld_wdata, overrun_clr,
           prom_3r_data, prom_3s_data,
    input  vid_r_data, vid_s_data, vid_valid, ld_ack, ld_rdata, vid_overrun,
           prom_3r_addr, prom_3r_wdata, prom_3r_we, prom_3r_ce,
           prom_3s_addr, prom_3s_wdata, prom_3s_we, prom_3s_ce
  );
endinterface

// File: rtl/clut_prom_arbiter.sv
// clut_prom_arbiter: shares the 3R/3S colour PROM RAMs between the 6 MHz video
// lookup path (absolute priority) and a runtime loader/debug port.
// Ports:
//   CLK_48M : master clock
//   reset   : asynchronous, active-high
//   bus_io  : clut_prom_arbiter_if.slave (video path, loader port, overrun flag,
//             PROM 3R/3S memory buses)
// Build option: define CLUT_ARB_BLANK_ONLY_EN to grant the loader only while
// blank = 1; by default blank is ignored.
module clut_prom_arbiter #(
  parameter int unsigned ADDR_W = 9
) (
  input logic                  CLK_48M,
  input logic                  reset,
  clut_prom_arbiter_if.slave   bus_io
);

  typedef enum logic [2:0] {StIdle, StVidRd, StVidCap, StLdAcc, StLdWait} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] vaddr_q, vaddr_d;
  logic              vid_pend_q, vid_pend_d;
  logic [ADDR_W-1:0] laddr_q, laddr_d;
  logic              lsel_q, lsel_d;
  logic              lwe_q, lwe_d;
  logic [7:0]        lwdata_q, lwdata_d;
  logic [7:0]        vid_r_q, vid_r_d;
  logic [3:0]        vid_s_q, vid_s_d;
  logic              vid_valid_q, vid_valid_d;
  logic              ld_ack_q, ld_ack_d;
  logic [7:0]        ld_rdata_q, ld_rdata_d;
  logic              overrun_q, overrun_d;
  logic [ADDR_W-1:0] addr_3r_q, addr_3r_d;
  logic [ADDR_W-1:0] addr_3s_q, addr_3s_d;
  logic              overrun_set;
  logic              ld_grant_ok;

`ifdef CLUT_ARB_BLANK_ONLY_EN
  assign ld_grant_ok = bus_io.blank;
`else
  logic unused_blank;
  assign unused_blank = bus_io.blank;
  assign ld_grant_ok  = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    vaddr_d     = vaddr_q;
    vid_pend_d  = vid_pend_q;
    laddr_d     = laddr_q;
    lsel_d      = lsel_q;
    lwe_d       = lwe_q;
    lwdata_d    = lwdata_q;
    vid_r_d     = vid_r_q;
    vid_s_d     = vid_s_q;
    vid_valid_d = 1'b0;
    ld_ack_d    = 1'b0;
    ld_rdata_d  = ld_rdata_q;
    overrun_set = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (vid_pend_q) begin
          state_d    = StVidRd;
          vid_pend_d = 1'b0;
          overrun_set = bus_io.pix_en;
        end else if (bus_io.pix_en) begin
          vaddr_d = bus_io.vid_addr;
          state_d = StVidRd;
        end else if (bus_io.ld_req && !ld_ack_q && ld_grant_ok) begin
          // ld_ack_q blocks re-granting a request still held in its ack cycle
          laddr_d  = bus_io.ld_addr;
          lsel_d   = bus_io.ld_sel;
          lwe_d    = bus_io.ld_we;
          lwdata_d = bus_io.ld_wdata;
          state_d  = StLdAcc;
        end
      end
      StVidRd: begin
        overrun_set = bus_io.pix_en;
        state_d     = StVidCap;
      end
      StVidCap: begin
        overrun_set = bus_io.pix_en;
        vid_r_d     = bus_io.prom_3r_data;
        vid_s_d     = bus_io.prom_3s_data;
        vid_valid_d = 1'b1;
        state_d     = StIdle;
      end
      StLdAcc, StLdWait: begin
        // Loader access is never aborted; a strobe is parked and served next
        if (bus_io.pix_en) begin
          if (vid_pend_q) begin
            overrun_set = 1'b1;
          end else begin
            vaddr_d    = bus_io.vid_addr;
            vid_pend_d = 1'b1;
          end
        end
        if (state_q == StLdAcc) begin
          state_d = StLdWait;
        end else begin
          if (!lwe_q) begin
            ld_rdata_d = lsel_q ? {4'b0000, bus_io.prom_3s_data} : bus_io.prom_3r_data;
          end
          ld_ack_d = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    overrun_d = overrun_set | (overrun_q & ~bus_io.overrun_clr);
  end

  // Address buses hold their last driven value outside the access states
  always_comb begin
    addr_3r_d = addr_3r_q;
    addr_3s_d = addr_3s_q;
    if (state_q == StVidRd) begin
      addr_3r_d = vaddr_q;
      addr_3s_d = vaddr_q;
    end else if (state_q == StLdAcc) begin
      if (lsel_q) addr_3s_d = laddr_q;
      else        addr_3r_d = laddr_q;
    end
  end

  always_ff @(posedge CLK_48M or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      vaddr_q     <= '0;
      vid_pend_q  <= 1'b0;
      laddr_q     <= '0;
      lsel_q      <= 1'b0;
      lwe_q       <= 1'b0;
      lwdata_q    <= '0;
      vid_r_q     <= '0;
      vid_s_q     <= '0;
      vid_valid_q <= 1'b0;
      ld_ack_q    <= 1'b0;
      ld_rdata_q  <= '0;
      overrun_q   <= 1'b0;
      addr_3r_q   <= '0;
      addr_3s_q   <= '0;
    end else begin
      state_q     <= state_d;
      vaddr_q     <= vaddr_d;
      vid_pend_q  <= vid_pend_d;
      laddr_q     <= laddr_d;
      lsel_q      <= lsel_d;
      lwe_q       <= lwe_d;
      lwdata_q    <= lwdata_d;
      vid_r_q     <= vid_r_d;
      vid_s_q     <= vid_s_d;
      vid_valid_q <= vid_valid_d;
      ld_ack_q    <= ld_ack_d;
      ld_rdata_q  <= ld_rdata_d;
      overrun_q   <= overrun_d;
      addr_3r_q   <= addr_3r_d;
      addr_3s_q   <= addr_3s_d;
    end
  end

  // ce/we decode from registered state only, so reset drops them immediately
  assign bus_io.prom_3r_ce    = (state_q == StVidRd) || (state_q == StLdAcc && !lsel_q);
  assign bus_io.prom_3s_ce    = (state_q == StVidRd) || (state_q == StLdAcc && lsel_q);
  assign bus_io.prom_3r_we    = (state_q == StLdAcc) && !lsel_q && lwe_q;
  assign bus_io.prom_3s_we    = (state_q == StLdAcc) && lsel_q && lwe_q;
  assign bus_io.prom_3r_addr  = addr_3r_d;
  assign bus_io.prom_3s_addr  = addr_3s_d;
  assign bus_io.prom_3r_wdata = lwdata_q;
  assign bus_io.prom_3s_wdata = lwdata_q[3:0];

  assign bus_io.vid_r_data  = vid_r_q;
  assign bus_io.vid_s_data  = vid_s_q;
  assign bus_io.vid_valid   = vid_valid_q;
  assign bus_io.ld_ack      = ld_ack_q;
  assign bus_io.ld_rdata    = ld_rdata_q;
  assign bus_io.vid_overrun = overrun_q;

endmodule

// File: tb/tb_clut_prom_arbiter.sv
// Testbench for clut_prom_arbiter: PROM RAM models, a shadow CLUT reference
// model, expected-response queues and a negedge monitor that checks each
// vid_valid / ld_ack against the queued expectation (data and latency).
module tb_clut_prom_arbiter;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  int   we_cnt;
  int   ce_cnt;
  logic preload;
  logic [7:0] salt;
  logic [7:0] ld_last;

  clut_prom_arbiter_if #(.ADDR_W(9)) bus ();

  clut_prom_arbiter #(.ADDR_W(9)) dut (
    .CLK_48M (clk),
    .reset   (rst),
    .bus_io  (bus)
  );

  typedef struct {
    logic [7:0] d;
    logic [3:0] s;
    int         cyc;
    int         lat;  // edges after the edge that first samples the request
  } exp_t;

  exp_t vq[$];
  exp_t lq[$];

  // Shadow CLUT contents (reference model)
  logic [7:0] sh_r [512];
  logic [3:0] sh_s [512];
  // PROM RAM contents
  logic [7:0] mem3r [512];
  logic [3:0] mem3s [512];

  function automatic logic [7:0] init_r(input int i);
    if (i == 'h105) return 8'hA7;
    return 8'(i * 73) ^ salt;
  endfunction

  function automatic logic [3:0] init_s(input int i);
    if (i == 'h105) return 4'h3;
    return 4'((i * 29 + int'(salt)) >> 2);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port synchronous RAMs: data valid at the edge after ce is sampled
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) begin
        mem3r[i] <= init_r(i);
        mem3s[i] <= init_s(i);
      end
    end else begin
      if (bus.prom_3r_ce) begin
        if (bus.prom_3r_we) mem3r[bus.prom_3r_addr] <= bus.prom_3r_wdata;
        bus.prom_3r_data <= mem3r[bus.prom_3r_addr];
      end
      if (bus.prom_3s_ce) begin
        if (bus.prom_3s_we) mem3s[bus.prom_3s_addr] <= bus.prom_3s_wdata;
        bus.prom_3s_data <= mem3s[bus.prom_3s_addr];
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.prom_3r_we || bus.prom_3s_we) we_cnt++;
    if (bus.prom_3r_ce || bus.prom_3s_ce) ce_cnt++;
    if (bus.vid_valid) begin
      chk("vid_valid_expected", int'(vq.size() > 0), 1);
      if (vq.size() > 0) begin
        e = vq.pop_front();
        chk("vid_r_data", int'(bus.vid_r_data), int'(e.d));
        chk("vid_s_data", int'(bus.vid_s_data), int'(e.s));
        chk("vid_latency", cyc - e.cyc - 1, e.lat);
      end
    end
    if (bus.ld_ack) begin
      chk("ld_ack_expected", int'(lq.size() > 0), 1);
      if (lq.size() > 0) begin
        e = lq.pop_front();
        chk("ld_rdata", int'(bus.ld_rdata), int'(e.d));
        if (e.lat >= 0) chk("ld_latency", cyc - e.cyc - 1, e.lat);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [8:0] a, input int lat, input bit keep);
    exp_t e;
    if (keep) begin
      e.d = sh_r[a]; e.s = sh_s[a]; e.cyc = cyc; e.lat = lat;
      vq.push_back(e);
    end
    bus.pix_en   = 1'b1;
    bus.vid_addr = a;
    @(posedge clk);
    #1;
    bus.pix_en = 1'b0;
  endtask

  task automatic ld_op(input logic sel, input logic we, input logic [8:0] a,
                       input logic [7:0] wd, input int lat);
    exp_t e;
    int   wc0;
    bit   got;
    if (we) begin
      if (sel) sh_s[a] = wd[3:0];
      else     sh_r[a] = wd;
      e.d = ld_last;  // writes leave ld_rdata unchanged
    end else begin
      e.d     = sel ? {4'b0000, sh_s[a]} : sh_r[a];
      ld_last = e.d;
    end
    e.s = 4'h0; e.cyc = cyc; e.lat = lat;
    lq.push_back(e);
    bus.ld_sel = sel; bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = wd;
    bus.ld_req = 1'b1;
    wc0 = we_cnt;
    got = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      #1;
      if (bus.ld_ack) begin
        got = 1'b1;
        break;
      end
    end
    bus.ld_req = 1'b0;
    chk("ld_ack_seen", int'(got), 1);
    chk("ld_we_pulses", we_cnt - wc0, int'(we));
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] a;
    int         k;
    int         ce0;

    salt    = 8'($urandom);
    ld_last = 8'h00;
    for (int i = 0; i < 512; i++) begin
      sh_r[i] = init_r(i);
      sh_s[i] = init_s(i);
    end
    rst = 1'b1; preload = 1'b1;
    bus.pix_en = 1'b0; bus.vid_addr = '0; bus.blank = 1'b1;
    bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_sel = 1'b0; bus.ld_addr = '0;
    bus.ld_wdata = '0; bus.overrun_clr = 1'b0;
    idle(3);

    // Reset state
    chk("rst_vid_valid", int'(bus.vid_valid), 0);
    chk("rst_ld_ack", int'(bus.ld_ack), 0);
    chk("rst_vid_overrun", int'(bus.vid_overrun), 0);
    chk("rst_ld_rdata", int'(bus.ld_rdata), 0);
    chk("rst_vid_r_data", int'(bus.vid_r_data), 0);
    chk("rst_ce", int'({bus.prom_3r_ce, bus.prom_3s_ce}), 0);
    chk("rst_we", int'({bus.prom_3r_we, bus.prom_3s_we}), 0);
    chk("rst_addr", int'({bus.prom_3r_addr, bus.prom_3s_addr}), 0);
    preload = 1'b0;
    rst     = 1'b0;
    idle(2);

    // Video read of preloaded entry
    pix(9'h105, 2, 1'b1);
    idle(8);

    // Loader write/read, 3R then 3S (3S reads back zero-extended)
    ld_op(1'b0, 1'b1, 9'h0FF, 8'h5C, 2);
    ld_op(1'b0, 1'b0, 9'h0FF, 8'h00, 2);
    ld_op(1'b1, 1'b1, 9'h0FF, 8'hF9, 2);
    ld_op(1'b1, 1'b0, 9'h0FF, 8'h00, 2);

    // Collision: strobe lands in LD_ACC, video follows the write
    fork
      ld_op(1'b0, 1'b1, 9'h0AB, 8'h6E, 2);
      begin
        @(posedge clk);
        #1;
        pix(9'h0AB, 4, 1'b1);
      end
    join
    idle(8);
    chk("collision_no_overrun", int'(bus.vid_overrun), 0);

    // Overrun: second strobe two cycles later is dropped
    pix(9'h010, 2, 1'b1);
    idle(1);
    pix(9'h011, 0, 1'b0);
    idle(8);
    chk("overrun_set", int'(bus.vid_overrun), 1);
    bus.overrun_clr = 1'b1;
    idle(1);
    bus.overrun_clr = 1'b0;
    chk("overrun_clr", int'(bus.vid_overrun), 0);
    pix(9'h012, 2, 1'b1);
    bus.overrun_clr = 1'b1;
    pix(9'h013, 0, 1'b0);
    bus.overrun_clr = 1'b0;
    chk("overrun_set_wins", int'(bus.vid_overrun), 1);
    idle(8);
    bus.overrun_clr = 1'b1;
    idle(1);
    bus.overrun_clr = 1'b0;

    // Reset in LD_ACC during a write: abandoned, no ack, RAM untouched
    bus.ld_sel = 1'b0; bus.ld_we = 1'b1; bus.ld_addr = 9'h0AA; bus.ld_wdata = 8'h33;
    bus.ld_req = 1'b1;
    idle(1);
    chk("pre_rst_3r_we", int'(bus.prom_3r_we), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_3r_we", int'(bus.prom_3r_we), 0);
    chk("rst_mid_3r_ce", int'(bus.prom_3r_ce), 0);
    bus.ld_req = 1'b0;
    ld_last    = 8'h00;
    idle(1);
    rst = 1'b0;
    idle(4);
    ld_op(1'b0, 1'b0, 9'h0AA, 8'h00, 2);

`ifdef CLUT_ARB_BLANK_ONLY_EN
    // Loader held off during active display, granted once blank rises
    bus.blank = 1'b0;
    ce0 = ce_cnt;
    fork
      ld_op(1'b0, 1'b1, 9'h0C3, 8'h81, 42);
      begin
        idle(40);
        chk("blank_no_ce", ce_cnt - ce0, 0);
        bus.blank = 1'b1;
      end
    join
    idle(2);
`else
    ce0 = 0;
`endif

    // Randomized mix over a small address pool so reads hit earlier writes
    for (int it = 0; it < 80; it++) begin
      k = int'($urandom_range(0, 2));
      a = 9'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) a[8] = 1'b1;
      if (k == 0) begin
        pix(a, 2, 1'b1);
        idle(7 + int'($urandom_range(0, 3)));
      end else begin
        ld_op(1'($urandom_range(0, 1)), (k == 1), a, 8'($urandom), 2);
        idle(int'($urandom_range(0, 2)));
      end
    end

    idle(10);
    chk("vid_queue_drained", vq.size(), 0);
    chk("ld_queue_drained", lq.size(), 0);
    chk("final_overrun", int'(bus.vid_overrun), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
